store_align_unit: RTL

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

---
 rtl/store_align_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/store_align_unit.sv
// Store alignment unit: lane-places SB/SH/SW data into word-aligned memory write beats.
// Optional macro STORE_MISALIGN_SPLIT_EN turns misaligned SH/SW into split beats instead of exceptions.
module store_align_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        mem_wvalid,
    input  logic        mem_wready,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        done,
    output logic        misalign_exc,
    output logic [31:0] exc_addr
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, EXC} state_e;

    state_e      state_q;
    logic        wvalid_q, done_q, exc_q, two_beat_q;
    logic [31:0] waddr_q, wdata_q, exc_addr_q, b1_data_q;
    logic [3:0]  wstrb_q, b1_strb_q;

    logic [1:0]  lane_off;
    logic [3:0]  size_mask;
    logic [7:0]  strb_wide;
    logic [63:0] data_wide;
    logic        misaligned, reserved;
    logic        exc_d, two_beat_d;
    logic [31:0] b0_data_d, b1_data_d;
    logic [3:0]  b0_strb_d, b1_strb_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        lane_off   = req_addr[1:0];
        size_mask  = 4'b0000;
        b0_data_d  = 32'h0;
        case (req_size)
            2'b00: begin size_mask = 4'b0001; b0_data_d = {4{req_data[7:0]}};  end
            2'b01: begin size_mask = 4'b0011; b0_data_d = {2{req_data[15:0]}}; end
            2'b10: begin size_mask = 4'b1111; b0_data_d = req_data;            end
            default: ;
        endcase
        // Shifting across a 64-bit window yields both beats: low half BEAT0, high half BEAT1.
        strb_wide  = {4'b0000, size_mask} << lane_off;
        data_wide  = {32'h0, req_data} << {lane_off, 3'b000};
        misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (lane_off != 2'b00));
        reserved   = (req_size == 2'b11);
        b0_strb_d  = strb_wide[3:0];
        b1_data_d  = data_wide[63:32];
        b1_strb_d  = strb_wide[7:4];
        two_beat_d = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
        exc_d = reserved;
        if (misaligned && !reserved) begin
            b0_data_d  = data_wide[31:0];
            two_beat_d = |strb_wide[7:4];
        end
`else
        exc_d = reserved || misaligned;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            exc_q      <= 1'b0;
            two_beat_q <= 1'b0;
            waddr_q    <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            exc_addr_q <= 32'h0;
            b1_data_q  <= 32'h0;
            b1_strb_q  <= 4'h0;
        end else begin
            done_q <= 1'b0;
            exc_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (exc_d) begin
                            state_q    <= EXC;
                            exc_q      <= 1'b1;
                            exc_addr_q <= req_addr;
                        end else begin
                            state_q    <= BEAT0;
                            wvalid_q   <= 1'b1;
                            waddr_q    <= {req_addr[31:2], 2'b00};
                            wdata_q    <= b0_data_d;
                            wstrb_q    <= b0_strb_d;
                            two_beat_q <= two_beat_d;
                            b1_data_q  <= b1_data_d;
                            b1_strb_q  <= b1_strb_d;
                        end
                    end
                end
                BEAT0: begin
                    if (mem_wready) begin
                        if (two_beat_q) begin
                            state_q <= BEAT1;
                            waddr_q <= waddr_q + 32'd4;
                            wdata_q <= b1_data_q;
                            wstrb_q <= b1_strb_q;
                        end else begin
                            state_q  <= IDLE;
                            wvalid_q <= 1'b0;
                            waddr_q  <= 32'h0;
                            wdata_q  <= 32'h0;
                            wstrb_q  <= 4'h0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_wready) begin
                        state_q  <= IDLE;
                        wvalid_q <= 1'b0;
                        waddr_q  <= 32'h0;
                        wdata_q  <= 32'h0;
                        wstrb_q  <= 4'h0;
                        done_q   <= 1'b1;
                    end
                end
                EXC: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready is masked by reset so nothing appears acceptable during the reset cycle.
    assign req_ready    = (state_q == IDLE) && !reset;
    assign mem_wvalid   = wvalid_q;
    assign mem_waddr    = waddr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wstrb    = wstrb_q;
    assign done         = done_q;
    assign misalign_exc = exc_q;
    assign exc_addr     = exc_addr_q;

endmodule
